// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, default widths and program entry-point table for pc_sequencer.
package seq_pkg;
  localparam int SEQ_PC_W = 10;
  localparam int SEQ_OFF_W = 8;
  localparam int SEQ_NUM_PROG = 4;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} seq_state_t;
  localparam logic [SEQ_PC_W-1:0] PROG_BASE [SEQ_NUM_PROG] = '{10'd0, 10'd128, 10'd256, 10'd384};
  // Indices at or beyond the configured program count fall back to base 0.
  function automatic logic [SEQ_PC_W-1:0] prog_base(input logic [1:0] sel, input int n);
    prog_base = '0;
    for (int i = 0; i < SEQ_NUM_PROG; i++)
      if (i < n && sel == 2'(i)) prog_base = PROG_BASE[i];
  endfunction
endpackage

// File: rtl/pc_sequencer_pc_next.sv
// pc_next: combinational next-PC adder, pc + 1 plus the sign-extended offset when taken (modulo 2^PC_W).
module pc_next #(
  parameter int PC_W = 10,
  parameter int OFF_W = 8
) (
  input  logic [PC_W-1:0]  pc_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic             taken_i,
  output logic [PC_W-1:0]  pc_o
);
  logic [PC_W-1:0] sext;
  assign sext = {{(PC_W-OFF_W){offset_i[OFF_W-1]}}, offset_i};
  assign pc_o = pc_i + PC_W'(1) + (taken_i ? sext : '0);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: run-control FSM and PC register for the single-cycle core.
// Optional WATCHDOG_EN adds WD_LIMIT and a timeout output that halts a runaway program.
module pc_sequencer import seq_pkg::*; #(
  parameter int PC_W = SEQ_PC_W,
  parameter int OFF_W = SEQ_OFF_W,
  parameter int CNT_W = 16,
  parameter int NUM_PROG = SEQ_NUM_PROG
`ifdef WATCHDOG_EN
  , parameter int WD_LIMIT = 4096
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       prog_sel,
  input  logic             done_instr,
  input  logic             branch_req,
  input  logic             cond_met,
  input  logic             is_branch,
  input  logic [OFF_W-1:0] offset,
  output logic [PC_W-1:0]  pc,
  output logic             instr_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
`ifdef WATCHDOG_EN
  , output logic           timeout
`endif
);
  seq_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_step;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic taken, wd_hit, stop;
  assign taken = branch_req & (~is_branch | cond_met);
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
  assign stop = done_instr | wd_hit;
  pc_next #(.PC_W(PC_W), .OFF_W(OFF_W)) u_pc_next (
    .pc_i(pc_q),
    .offset_i(offset),
    .taken_i(taken),
    .pc_o(pc_step)
  );
`ifdef WATCHDOG_EN
  logic to_q, to_d;
  assign wd_hit = 32'(cnt_inc) >= 32'(WD_LIMIT);
  assign to_d = state_d == LOAD ? 1'b0 :
                (state_q == RUN && !start && !done_instr && wd_hit) ? 1'b1 : to_q;
  assign timeout = to_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) to_q <= 1'b0;
    else to_q <= to_d;
`else
  assign wd_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: begin
        state_d = start ? LOAD : RUN;
        pc_d = PC_W'(prog_base(prog_sel, NUM_PROG));
        cnt_d = '0;
      end
      RUN: begin
        cnt_d = cnt_inc;
        state_d = start ? LOAD : stop ? HALT : RUN;
        pc_d = (start | ~stop) ? pc_step : pc_q;
      end
      HALT: state_d = start ? LOAD : HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      pc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
    end
  assign pc = pc_q;
  assign instr_valid = state_q == RUN;
  assign busy = state_q == LOAD || state_q == RUN;
  assign done = state_q == HALT;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven RUN vectors through a scoreboard queue plus hand-written launch/halt/reset sequences.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] prog_sel = 2'd0;
  logic done_instr = 1'b0, branch_req = 1'b0, cond_met = 1'b0, is_branch = 1'b0;
  logic [7:0] offset = 8'd0;
  logic [9:0] pc;
  logic instr_valid, busy, done;
  logic [15:0] instr_count;
`ifdef WATCHDOG_EN
  logic timeout;
`endif
  int total = 0;
  int bad = 0;

  typedef struct {logic br; logic isb; logic cm; logic [7:0] off; logic [9:0] epc;} vec_t;
  typedef struct {logic [9:0] pc; logic [15:0] cnt;} exp_t;
  vec_t tbl[15];
  exp_t sb[$];

`ifdef WATCHDOG_EN
  pc_sequencer #(.WD_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
    .done_instr(done_instr), .branch_req(branch_req), .cond_met(cond_met),
    .is_branch(is_branch), .offset(offset), .pc(pc), .instr_valid(instr_valid),
    .busy(busy), .done(done), .instr_count(instr_count), .timeout(timeout)
  );
`else
  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
    .done_instr(done_instr), .branch_req(branch_req), .cond_met(cond_met),
    .is_branch(is_branch), .offset(offset), .pc(pc), .instr_valid(instr_valid),
    .busy(busy), .done(done), .instr_count(instr_count)
  );
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic isb, input logic cm, input logic [7:0] off);
    branch_req = br;
    is_branch = isb;
    cond_met = cm;
    offset = off;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd9,   10'd10};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'hFB,  10'd6};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'd3,   10'd10};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'hFB,  10'd11};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h7F,  10'd12};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'hFD,  10'd10};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'd20,  10'd31};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'hDF,  10'd1023};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'd0,   10'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'hFB,  10'd1020};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 8'd10,  10'd7};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h7F,  10'd8};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h80,  10'd905};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 8'd100, 10'd1006};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 8'd67,  10'd50};

    #2;
    chk("rst_pc", pc, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_cnt", instr_count, 0);
    tick();
    reset = 1'b0;

    start = 1'b1;
    prog_sel = 2'd1;
    tick();
    tick();
    tick();
    chk("load_pc", pc, 128);
    chk("load_busy", busy, 1);
    chk("load_valid", instr_valid, 0);
    start = 1'b0;
    tick();
    chk("run0_pc", pc, 128);
    chk("run0_valid", instr_valid, 1);
    chk("run0_cnt", instr_count, 0);
    tick();
    chk("run1_pc", pc, 129);
    chk("run1_cnt", instr_count, 1);

    start = 1'b1;
    prog_sel = 2'd0;
    tick();
    chk("abort_valid", instr_valid, 0);
    tick();
    chk("abort_pc", pc, 0);
    start = 1'b0;
    tick();
    chk("p0_pc", pc, 0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].br, tbl[i].isb, tbl[i].cm, tbl[i].off);
      sb.push_back('{tbl[i].epc, 16'(i + 1)});
      tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d_pc", i), pc, e.pc);
      chk($sformatf("vec%0d_cnt", i), instr_count, e.cnt);
    end

    done_instr = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'd20);
    tick();
    chk("halt_pc", pc, 50);
    chk("halt_done", done, 1);
    chk("halt_busy", busy, 0);
    chk("halt_cnt", instr_count, 16);
    done_instr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    chk("halt_hold_pc", pc, 50);
    chk("halt_hold_done", done, 1);
    start = 1'b1;
    prog_sel = 2'd2;
    tick();
    chk("relaunch_done", done, 0);
    chk("relaunch_busy", busy, 1);
    tick();
    chk("relaunch_pc", pc, 256);
    start = 1'b0;
    tick();
    chk("relaunch_run_pc", pc, 256);
    chk("relaunch_cnt", instr_count, 0);

    done_instr = 1'b1;
    start = 1'b1;
    tick();
    chk("start_prio_done", done, 0);
    chk("start_prio_valid", instr_valid, 0);
    done_instr = 1'b0;
    tick();
    start = 1'b0;
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h80);
    tick();
    chk("to129_pc", pc, 129);
    drive(1'b1, 1'b0, 1'b0, 8'hA3);
    tick();
    chk("to37_pc", pc, 37);
    reset = 1'b1;
    #1;
    chk("async_pc", pc, 0);
    chk("async_done", done, 0);
    chk("async_busy", busy, 0);
    chk("async_cnt", instr_count, 0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    reset = 1'b0;

`ifdef WATCHDOG_EN
    start = 1'b1;
    prog_sel = 2'd0;
    tick();
    tick();
    start = 1'b0;
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'hFF);
    repeat (7) tick();
    chk("wd_early_done", done, 0);
    tick();
    chk("wd_done", done, 1);
    chk("wd_timeout", timeout, 1);
    chk("wd_cnt", instr_count, 8);
    tick();
    chk("wd_pc", pc, 0);
    start = 1'b1;
    tick();
    chk("wd_clear", timeout, 0);
    start = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Run-control and program-counter sequencer for the single-cycle core. Owns the PC register and the start/done handshake with the testbench. Selects PC+1 or PC+1+offset from the decoder's branch request and the ALU condition flag, and freezes the core once a done instruction retires. Sits between the top-level start/done pins, the instruction ROM address and the decoder.

Parameters:
PC_W, 10, PC and instruction-ROM address width
OFF_W, 8, branch/jump offset width (two's complement)
CNT_W, 16, retired-instruction counter width
NUM_PROG, 4, number of program entry points (base table in package)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; high holds the core in load, falling edge launches the program
prog_sel  in  2  program index, sampled in LOAD
done_instr  in  1  decoder done (done opcode decoded this cycle)
branch_req  in  1  decoder next_branch_selector
cond_met  in  1  ALU flag selected by branch_sel; ignored for jump
is_branch  in  1  decoder branch (conditional); 0 means unconditional jump
offset  in  OFF_W  signed branch displacement
pc  out  PC_W  instruction ROM address
instr_valid  out  1  high only in RUN; gates register and memory writes
busy  out  1  high in LOAD or RUN
done  out  1  level, high in HALT
instr_count  out  CNT_W  instructions retired since last launch

Behaviour:
- Reset: state=IDLE, pc=0, instr_count=0, every output low/zero.
- States: IDLE, LOAD, RUN, HALT. Registered state; Moore outputs.
- IDLE: start=1 -> LOAD.
- LOAD: pc <= PROG_BASE[prog_sel] every cycle; instr_count <= 0; instr_valid=0. start=0 -> RUN, first fetch at the base address.
- RUN: instr_valid=1. Each cycle instr_count increments, saturating at all-ones.
  - taken = branch_req & (~is_branch | cond_met).
  - taken: pc <= pc + 1 + sext(offset).
  - not taken: pc <= pc + 1.
  - Arithmetic is modulo 2^PC_W; wrap-around is silent.
  - done_instr=1 -> HALT; pc holds, and done_instr has priority over any simultaneous branch_req. The done instruction counts as retired.
  - start=1 in RUN -> abort to LOAD (restart); start has priority over done_instr.
- HALT: done=1, pc holds. start=1 -> LOAD; done drops the cycle LOAD is entered.
- prog_sel index >= NUM_PROG selects base 0.
- Asynchronous reset in any state returns to IDLE immediately.
- Latency: pc reflects a taken branch one clock after the branch instruction; done rises one clock after done_instr.

Optional Feature:
WATCHDOG_EN:
- With it: a parameter WD_LIMIT (default 4096) and an output timeout (1 bit) are added. If instr_count reaches WD_LIMIT in RUN, the block enters HALT with done=1 and timeout=1. timeout clears on entry to LOAD or on reset.
- Without it: no timeout port; RUN continues until done_instr or start.

Decomposition:
- Package seq_pkg holds:
  - state enum seq_state_t {IDLE, LOAD, RUN, HALT}
  - PROG_BASE array of NUM_PROG PC_W-bit entry points (defaults 0, 128, 256, 384)
  - PC_W/OFF_W defaults
- One sub-module is natural: pc_next, a combinational next-PC adder (pc, offset, taken -> next pc), reused by the disassembly checker.

Test Plan:
- Reset mid-RUN at pc=37 -> state IDLE, pc=0, done=0 asynchronously before the next edge.
- start high 3 cycles with prog_sel=1, then low -> pc=128 during LOAD; first RUN cycle fetches 128; next cycle 129; instr_count=1.
- Conditional branch at pc=10, offset=-5 (0xFB): cond_met=1 -> pc=6; cond_met=0 -> pc=11. Jump (is_branch=0, cond_met=0), offset=+20 -> pc=31.
- Wrap: pc=1023, not taken -> pc=0; pc=1020, offset=+10 taken -> pc=7.
- done_instr and branch_req in the same cycle at pc=50 -> HALT, pc stays 50, done=1 next cycle. Then start=1 -> done=0, relaunch to PROG_BASE.
- With WATCHDOG_EN and WD_LIMIT=8, branch-to-self loop (offset=-1, taken) -> after 8 retired instructions done=1, timeout=1, pc frozen.
